// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG byte-stream packer: the grayscale header
// image, marker bytes, patch offsets, FSM state encoding and byte helpers.
package jpeg_pkg;

   localparam int HDR_BYTES = 328;
   localparam int HDR_H_OFS = 94;
   localparam int HDR_W_OFS = 96;

   localparam logic [15:0] SOI        = 16'hFFD8;
   localparam logic [15:0] EOI        = 16'hFFD9;
   localparam logic [7:0]  STUFF_BYTE = 8'h00;
   localparam logic [7:0]  MARKER_FF  = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_STUFF,
      ST_EOI_FF,
      ST_EOI_D9
   } state_t;

   // SOI, APP0/JFIF, DQT (luminance, zig-zag), SOF0 (1 component, size
   // fields zero and patched at run time), DHT DC0, DHT AC0, SOS.
   localparam logic [7:0] JPEG_HDR [0:HDR_BYTES-1] = '{
      8'hFF,8'hD8,8'hFF,8'hE0,8'h00,8'h10,8'h4A,8'h46,8'h49,8'h46,8'h00,8'h01,8'h01,8'h00,8'h00,8'h01,8'h00,8'h01,8'h00,8'h00,
      8'hFF,8'hDB,8'h00,8'h43,8'h00,
      8'h10,8'h0B,8'h0C,8'h0E,8'h0C,8'h0A,8'h10,8'h0E,8'h0D,8'h0E,8'h12,8'h11,8'h10,8'h13,8'h18,8'h28,
      8'h1A,8'h18,8'h16,8'h16,8'h18,8'h31,8'h23,8'h25,8'h1D,8'h28,8'h3A,8'h33,8'h3D,8'h3C,8'h39,8'h33,
      8'h38,8'h37,8'h40,8'h48,8'h5C,8'h4E,8'h40,8'h44,8'h57,8'h45,8'h37,8'h38,8'h50,8'h6D,8'h51,8'h57,
      8'h5F,8'h62,8'h67,8'h68,8'h67,8'h3E,8'h4D,8'h71,8'h79,8'h70,8'h64,8'h78,8'h5C,8'h65,8'h67,8'h63,
      8'hFF,8'hC0,8'h00,8'h0B,8'h08,8'h00,8'h00,8'h00,8'h00,8'h01,8'h01,8'h11,8'h00,
      8'hFF,8'hC4,8'h00,8'h1F,8'h00,
      8'h00,8'h01,8'h05,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
      8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,8'h0A,8'h0B,
      8'hFF,8'hC4,8'h00,8'hB5,8'h10,
      8'h00,8'h02,8'h01,8'h03,8'h03,8'h02,8'h04,8'h03,8'h05,8'h05,8'h04,8'h04,8'h00,8'h00,8'h01,8'h7D,
      8'h01,8'h02,8'h03,8'h00,8'h04,8'h11,8'h05,8'h12,8'h21,8'h31,8'h41,8'h06,8'h13,8'h51,8'h61,8'h07,
      8'h22,8'h71,8'h14,8'h32,8'h81,8'h91,8'hA1,8'h08,8'h23,8'h42,8'hB1,8'hC1,8'h15,8'h52,8'hD1,8'hF0,
      8'h24,8'h33,8'h62,8'h72,8'h82,8'h09,8'h0A,8'h16,8'h17,8'h18,8'h19,8'h1A,8'h25,8'h26,8'h27,8'h28,
      8'h29,8'h2A,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h3A,8'h43,8'h44,8'h45,8'h46,8'h47,8'h48,8'h49,
      8'h4A,8'h53,8'h54,8'h55,8'h56,8'h57,8'h58,8'h59,8'h5A,8'h63,8'h64,8'h65,8'h66,8'h67,8'h68,8'h69,
      8'h6A,8'h73,8'h74,8'h75,8'h76,8'h77,8'h78,8'h79,8'h7A,8'h83,8'h84,8'h85,8'h86,8'h87,8'h88,8'h89,
      8'h8A,8'h92,8'h93,8'h94,8'h95,8'h96,8'h97,8'h98,8'h99,8'h9A,8'hA2,8'hA3,8'hA4,8'hA5,8'hA6,8'hA7,
      8'hA8,8'hA9,8'hAA,8'hB2,8'hB3,8'hB4,8'hB5,8'hB6,8'hB7,8'hB8,8'hB9,8'hBA,8'hC2,8'hC3,8'hC4,8'hC5,
      8'hC6,8'hC7,8'hC8,8'hC9,8'hCA,8'hD2,8'hD3,8'hD4,8'hD5,8'hD6,8'hD7,8'hD8,8'hD9,8'hDA,8'hE1,8'hE2,
      8'hE3,8'hE4,8'hE5,8'hE6,8'hE7,8'hE8,8'hE9,8'hEA,8'hF1,8'hF2,8'hF3,8'hF4,8'hF5,8'hF6,8'hF7,8'hF8,
      8'hF9,8'hFA,
      8'hFF,8'hDA,8'h00,8'h08,8'h01,8'h01,8'h00,8'h00,8'h3F,8'h00
   };

   // Header byte at idx with the SOF0 height/width fields substituted.
   function automatic logic [7:0] hdr_byte(input logic [8:0] idx,
                                           input logic [15:0] h,
                                           input logic [15:0] w);
      if (idx == 9'(HDR_H_OFS))          return h[15:8];
      else if (idx == 9'(HDR_H_OFS + 1)) return h[7:0];
      else if (idx == 9'(HDR_W_OFS))     return w[15:8];
      else if (idx == 9'(HDR_W_OFS + 1)) return w[7:0];
      else                               return JPEG_HDR[idx];
   endfunction

   // Byte s of an encoder word, most significant byte first.
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] s);
      case (s)
         2'd0:    return w[31:24];
         2'd1:    return w[23:16];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// Single-clock word FIFO with show-ahead read data. A pop and a push in the
// same cycle are both honoured even when full, since the pop frees the slot.
module jpeg_word_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk_x8_i,
   input  logic                       rst_n_i,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [31:0]                wr_data,
   input  logic                       rd_en,
   output logic [31:0]                rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because count gates reads.
   always_ff @(posedge clk_x8_i) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/jpeg_stream_packer.sv
// Packs the encoder's 32-bit word stream into a byte-serial JPEG file:
// patched header, byte-stuffed scan data, then EOI.
//
// Output handshake: a byte transfers on any cycle where byte_valid_o and
// byte_ready_i are both high. While byte_valid_o is high and byte_ready_i is
// low, byte_o and its sof/eof flags hold; byte_valid_o only falls after a
// transfer. The output register reloads whenever it is empty or draining.
module jpeg_stream_packer
   import jpeg_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int HDR_LEN    = 328
) (
   input  logic        clk_x8_i,
   input  logic        rst_n_i,
   input  logic [15:0] pic_width_i,
   input  logic [15:0] pic_height_i,
   input  logic        frame_start_i,
   input  logic        frame_end_i,
   input  logic [31:0] enc_word_i,
   input  logic        enc_valid_i,
   output logic [7:0]  byte_o,
   output logic        byte_valid_o,
   input  logic        byte_ready_i,
   output logic        byte_sof_o,
   output logic        byte_eof_o,
   output logic        ovf_o,
   output logic        busy_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   state_t        state;
   logic [15:0]   width_q;
   logic [15:0]   height_q;
   logic [8:0]    hdr_idx;
   logic          end_pend;
   logic [31:0]   cur_word;
   logic [1:0]    cur_sel;
   logic          cur_valid;

   logic          fifo_clr;
   logic          fifo_wr;
   logic          fifo_rd;
   logic          fifo_full;
   logic          fifo_empty;
   logic [31:0]   fifo_rdata;
   logic [AW:0]   fifo_count;

   logic          adv;
   logic [31:0]   src_word;
   logic [1:0]    src_sel;
   logic [7:0]    data_byte;
   logic          data_avail;

   assign adv        = !byte_valid_o || byte_ready_i;
   // A partly emitted word takes priority; otherwise the FIFO head is used
   // directly so a new word starts without a bubble.
   assign src_word   = cur_valid ? cur_word : fifo_rdata;
   assign src_sel    = cur_valid ? cur_sel  : 2'd0;
   assign data_byte  = word_byte(src_word, src_sel);
   assign data_avail = cur_valid || !fifo_empty;
   assign fifo_rd    = (state == ST_DATA) && adv && !cur_valid && !fifo_empty;
   assign fifo_wr    = enc_valid_i && (state != ST_IDLE);
   assign fifo_clr   = (state == ST_IDLE) && frame_start_i;
   assign busy_o     = (state != ST_IDLE);

   jpeg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_x8_i (clk_x8_i),
      .rst_n_i  (rst_n_i),
      .clr      (fifo_clr),
      .wr_en    (fifo_wr),
      .wr_data  (enc_word_i),
      .rd_en    (fifo_rd),
      .rd_data  (fifo_rdata),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Framing FSM; each state loads the next byte into the output register.
   always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= ST_IDLE;
         width_q      <= '0;
         height_q     <= '0;
         hdr_idx      <= '0;
         end_pend     <= 1'b0;
         cur_word     <= '0;
         cur_sel      <= '0;
         cur_valid    <= 1'b0;
         byte_o       <= 8'h00;
         byte_valid_o <= 1'b0;
         byte_sof_o   <= 1'b0;
         byte_eof_o   <= 1'b0;
         ovf_o        <= 1'b0;
      end else begin
         if (fifo_wr && fifo_full && !fifo_rd) ovf_o <= 1'b1;
         if (frame_end_i && state != ST_IDLE)  end_pend <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (frame_start_i) begin
                  width_q   <= pic_width_i;
                  height_q  <= pic_height_i;
                  ovf_o     <= 1'b0;
                  end_pend  <= 1'b0;
                  hdr_idx   <= '0;
                  cur_valid <= 1'b0;
                  state     <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (adv) begin
                  byte_o       <= hdr_byte(hdr_idx, height_q, width_q);
                  byte_valid_o <= 1'b1;
                  byte_sof_o   <= (hdr_idx == 9'd0);
                  byte_eof_o   <= 1'b0;
                  if (hdr_idx == 9'(HDR_LEN - 1)) state <= ST_DATA;
                  else hdr_idx <= hdr_idx + 9'd1;
               end
            end
            ST_DATA: begin
               if (adv) begin
                  byte_sof_o <= 1'b0;
                  byte_eof_o <= 1'b0;
                  if (data_avail) begin
                     byte_o       <= data_byte;
                     byte_valid_o <= 1'b1;
                     cur_word     <= src_word;
                     if (src_sel == 2'd3) begin
                        cur_valid <= 1'b0;
                     end else begin
                        cur_valid <= 1'b1;
                        cur_sel   <= src_sel + 2'd1;
                     end
                     if (data_byte == MARKER_FF) state <= ST_STUFF;
                  end else begin
                     byte_valid_o <= 1'b0;
                     if (end_pend && fifo_count == '0) state <= ST_EOI_FF;
                  end
               end
            end
            ST_STUFF: begin
               if (adv) begin
                  byte_o       <= STUFF_BYTE;
                  byte_valid_o <= 1'b1;
                  state        <= ST_DATA;
               end
            end
            ST_EOI_FF: begin
               if (adv) begin
                  byte_o       <= EOI[15:8];
                  byte_valid_o <= 1'b1;
                  byte_sof_o   <= 1'b0;
                  byte_eof_o   <= 1'b0;
                  state        <= ST_EOI_D9;
               end
            end
            ST_EOI_D9: begin
               if (adv) begin
                  if (byte_eof_o) begin
                     // D9 is being accepted: the frame is complete.
                     byte_valid_o <= 1'b0;
                     byte_eof_o   <= 1'b0;
                     state        <= ST_IDLE;
                  end else begin
                     byte_o       <= EOI[7:0];
                     byte_valid_o <= 1'b1;
                     byte_eof_o   <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_stream_packer.sv
// Directed bench for jpeg_stream_packer: expected bytes are queued as the
// stimulus is driven and checked in order as the sink observes them.
module tb_jpeg_stream_packer;

   logic        clk_x8_i;
   logic        rst_n_i;
   logic [15:0] pic_width_i;
   logic [15:0] pic_height_i;
   logic        frame_start_i;
   logic        frame_end_i;
   logic [31:0] enc_word_i;
   logic        enc_valid_i;
   logic [7:0]  byte_o;
   logic        byte_valid_o;
   logic        byte_ready_i;
   logic        byte_sof_o;
   logic        byte_eof_o;
   logic        ovf_o;
   logic        busy_o;

   // Entry: {care_byte, eof, sof, byte}
   logic [10:0] exp_q[$];
   logic [10:0] mon_e;
   int          checks = 0;
   int          passes = 0;
   int          fails  = 0;
   int          n_acc  = 0;
   int          ready_mode = 0;   // 0: always ready, 1: toggle, 2: hold low
   logic        prev_stall = 1'b0;

   jpeg_stream_packer #(.FIFO_DEPTH(16), .HDR_LEN(328)) dut (
      .clk_x8_i      (clk_x8_i),
      .rst_n_i       (rst_n_i),
      .pic_width_i   (pic_width_i),
      .pic_height_i  (pic_height_i),
      .frame_start_i (frame_start_i),
      .frame_end_i   (frame_end_i),
      .enc_word_i    (enc_word_i),
      .enc_valid_i   (enc_valid_i),
      .byte_o        (byte_o),
      .byte_valid_o  (byte_valid_o),
      .byte_ready_i  (byte_ready_i),
      .byte_sof_o    (byte_sof_o),
      .byte_eof_o    (byte_eof_o),
      .ovf_o         (ovf_o),
      .busy_o        (busy_o)
   );

   // Clock
   initial begin
      clk_x8_i = 1'b0;
      forever #5 clk_x8_i = ~clk_x8_i;
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s (byte #%0d): got 0x%0h, want 0x%0h", name, n_acc, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk_x8_i);
      #1;
   endtask

   task automatic push_b(input logic care, input logic eof, input logic sof, input logic [7:0] b);
      exp_q.push_back({care, eof, sof, b});
   endtask

   // Header bytes the bench knows independently: markers, JFIF tag,
   // patched size fields and the final SOS byte.
   function automatic logic [8:0] hdr_known(input int i, input logic [15:0] h, input logic [15:0] w);
      case (i)
         0, 2, 20, 89, 102, 135, 318: return {1'b1, 8'hFF};
         1:   return {1'b1, 8'hD8};
         3:   return {1'b1, 8'hE0};
         6:   return {1'b1, 8'h4A};
         7:   return {1'b1, 8'h46};
         8:   return {1'b1, 8'h49};
         9:   return {1'b1, 8'h46};
         21:  return {1'b1, 8'hDB};
         90:  return {1'b1, 8'hC0};
         94:  return {1'b1, h[15:8]};
         95:  return {1'b1, h[7:0]};
         96:  return {1'b1, w[15:8]};
         97:  return {1'b1, w[7:0]};
         103, 136: return {1'b1, 8'hC4};
         319: return {1'b1, 8'hDA};
         327: return {1'b1, 8'h00};
         default: return {1'b0, 8'h00};
      endcase
   endfunction

   task automatic push_header(input logic [15:0] h, input logic [15:0] w);
      logic [8:0] k;
      for (int i = 0; i < 328; i++) begin
         k = hdr_known(i, h, w);
         push_b(k[8], 1'b0, (i == 0), k[7:0]);
      end
   endtask

   task automatic push_word(input logic [31:0] wd);
      logic [7:0] b;
      for (int i = 3; i >= 0; i--) begin
         b = wd[8*i +: 8];
         push_b(1'b1, 1'b0, 1'b0, b);
         if (b == 8'hFF) push_b(1'b1, 1'b0, 1'b0, 8'h00);
      end
   endtask

   task automatic push_eoi();
      push_b(1'b1, 1'b0, 1'b0, 8'hFF);
      push_b(1'b1, 1'b1, 1'b0, 8'hD9);
   endtask

   task automatic start_frame(input logic [15:0] h, input logic [15:0] w);
      pic_height_i  = h;
      pic_width_i   = w;
      frame_start_i = 1'b1;
      push_header(h, w);
      tick();
      frame_start_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] wd, input logic expect_out);
      enc_word_i  = wd;
      enc_valid_i = 1'b1;
      if (expect_out) push_word(wd);
      tick();
      enc_valid_i = 1'b0;
   endtask

   task automatic end_frame();
      frame_end_i = 1'b1;
      push_eoi();
      tick();
      frame_end_i = 1'b0;
   endtask

   task automatic send_last(input logic [31:0] wd);
      enc_word_i  = wd;
      enc_valid_i = 1'b1;
      frame_end_i = 1'b1;
      push_word(wd);
      push_eoi();
      tick();
      enc_valid_i = 1'b0;
      frame_end_i = 1'b0;
   endtask

   // Waits for D9 to be accepted, then expects busy_o low the next cycle.
   task automatic wait_eof(input int max);
      logic found = 1'b0;
      for (int n = 0; n < max && !found; n++) begin
         @(negedge clk_x8_i);
         if (byte_valid_o && byte_ready_i && byte_eof_o) found = 1'b1;
      end
      chk("eof_seen", found, 1'b1);
      @(posedge clk_x8_i);
      #1;
      chk("busy_after_eof", busy_o, 1'b0);
   endtask

   task automatic wait_drain(input int max);
      int n = 0;
      while ((exp_q.size() != 0 || byte_valid_o) && n < max) begin
         tick();
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   // Sink ready pattern
   initial begin
      byte_ready_i = 1'b1;
      forever begin
         @(posedge clk_x8_i);
         #1;
         case (ready_mode)
            0:       byte_ready_i = 1'b1;
            1:       byte_ready_i = ~byte_ready_i;
            default: byte_ready_i = 1'b0;
         endcase
      end
   end

   // Scoreboard: every valid byte must match the queue head, stalled or not.
   initial begin
      forever begin
         @(negedge clk_x8_i);
         if (rst_n_i) begin
            if (prev_stall) chk("valid_hold", byte_valid_o, 1'b1);
            if (byte_valid_o) begin
               chk("byte_expected", (exp_q.size() != 0), 1'b1);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q[0];
                  chk("sof", byte_sof_o, mon_e[8]);
                  chk("eof", byte_eof_o, mon_e[9]);
                  if (mon_e[10]) chk("byte", byte_o, mon_e[7:0]);
                  if (byte_ready_i) begin
                     void'(exp_q.pop_front());
                     n_acc++;
                  end
               end
            end
            prev_stall = byte_valid_o && !byte_ready_i;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // Directed sequence
   initial begin
      rst_n_i       = 1'b0;
      pic_width_i   = '0;
      pic_height_i  = '0;
      frame_start_i = 1'b0;
      frame_end_i   = 1'b0;
      enc_word_i    = '0;
      enc_valid_i   = 1'b0;
      repeat (3) tick();
      chk("rst_byte",  byte_o, 8'h00);
      chk("rst_valid", byte_valid_o, 1'b0);
      chk("rst_sof",   byte_sof_o, 1'b0);
      chk("rst_eof",   byte_eof_o, 1'b0);
      chk("rst_ovf",   ovf_o, 1'b0);
      chk("rst_busy",  busy_o, 1'b0);
      rst_n_i = 1'b1;
      tick();

      // Words in IDLE are dropped silently
      send_word(32'hDEADBEEF, 1'b0);
      chk("idle_no_ovf", ovf_o, 1'b0);
      chk("idle_busy", busy_o, 1'b0);

      // Frame A: header patch, stuffing, last word with frame_end
      start_frame(16'd1080, 16'd744);
      chk("lat_t1_valid", byte_valid_o, 1'b0);
      chk("busy_header", busy_o, 1'b1);
      tick();
      chk("lat_t2_valid", byte_valid_o, 1'b1);
      chk("lat_t2_sof", byte_sof_o, 1'b1);
      chk("lat_t2_byte", byte_o, 8'hFF);
      send_word(32'h12FF34FF, 1'b1);
      send_word(32'hFFFFFFFF, 1'b1);
      send_last(32'h01020304);
      wait_eof(1000);
      wait_drain(100);

      // Frame B: toggling ready, plus a start pulse while busy
      ready_mode = 1;
      start_frame(16'd1080, 16'd744);
      pic_width_i   = 16'd1;
      pic_height_i  = 16'd1;
      frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
      send_word(32'h12FF34FF, 1'b1);
      send_word(32'hA5FF00FF, 1'b1);
      end_frame();
      wait_eof(2000);
      wait_drain(100);
      ready_mode = 0;

      // Frame C: overflow during a stalled header
      ready_mode = 2;
      tick();
      start_frame(16'd48, 16'd64);
      for (int i = 0; i < 20; i++) send_word($urandom, (i < 16));
      chk("ovf_set", ovf_o, 1'b1);
      ready_mode = 0;
      end_frame();
      wait_eof(2000);
      wait_drain(100);
      chk("ovf_sticky", ovf_o, 1'b1);

      // Frame D: overflow clears at the next accepted start
      start_frame(16'd16, 16'd16);
      chk("ovf_cleared", ovf_o, 1'b0);
      send_last($urandom_range(32'hFFFF_FFFF, 0));
      wait_eof(1000);
      wait_drain(100);

      // Frame E: reset while streaming data
      start_frame(16'd8, 16'd8);
      for (int i = 0; i < 8; i++) send_word(32'hFFFFFFFF, 1'b1);
      repeat (330) tick();
      chk("busy_data", busy_o, 1'b1);
      rst_n_i = 1'b0;
      #1;
      chk("mid_rst_byte",  byte_o, 8'h00);
      chk("mid_rst_valid", byte_valid_o, 1'b0);
      chk("mid_rst_sof",   byte_sof_o, 1'b0);
      chk("mid_rst_eof",   byte_eof_o, 1'b0);
      chk("mid_rst_ovf",   ovf_o, 1'b0);
      chk("mid_rst_busy",  busy_o, 1'b0);
      exp_q.delete();
      repeat (2) tick();
      rst_n_i = 1'b1;
      tick();

      // Frame F: fresh frame after reset
      start_frame(16'd1080, 16'd744);
      send_last(32'hCAFEFF00);
      wait_eof(1000);
      wait_drain(100);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
